axi_wb_chn_router: RTL and testbench

Parametrised W/B channel router for the AXI interconnect. It sits between the AW arbiter and one downstream AXI slave port. It routes the W data of granted upstream masters to the slave in grant order, and routes B responses back in completion order. An internal W-order FIFO and B-order FIFO let the next burst's W beats proceed while earlier B responses are still pending.

---
 rtl/axi_ic_pkg.sv | 22 ++
 rtl/order_fifo.sv | 56 +++++
 rtl/axi_wb_chn_router.sv | 124 ++++++++++++
 tb/tb_axi_wb_chn_router.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect: ceil-log2 helper, BRESP codes
// and the master-count limit.
package axi_ic_pkg;

    localparam int MAX_MASTER_N = 16;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Ceiling log2; clogb2(1) = 0, clogb2(4) = 2, clogb2(5) = 3.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/order_fifo.sv
// Small synchronous FIFO holding master IDs in order; the head is presented
// straight from the storage registers so it is valid the cycle after a push.
module order_fifo
    import axi_ic_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int AW   = clogb2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_en, pop_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/axi_wb_chn_router.sv
// W/B channel router: steers W beats of granted masters to one slave in grant
// order and returns B responses in burst-completion order.
module axi_wb_chn_router
    import axi_ic_pkg::*;
#(
    parameter int MASTER_N          = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int OUTSTANDING_DEPTH = 4,
    parameter int simulation_delay  = 1,
    localparam int MID_W  = clogb2(MASTER_N - 1) + 1,
    localparam int STRB_W = DATA_WIDTH / 8,
    localparam int CNT_W  = clogb2(OUTSTANDING_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         grant_push_valid,
    output logic                         grant_push_ready,
    input  logic [MID_W-1:0]             grant_push_mid,
    input  logic [MASTER_N*DATA_WIDTH-1:0] s_w_data,
    input  logic [MASTER_N*STRB_W-1:0]   s_w_strb,
    input  logic [MASTER_N-1:0]          s_w_last,
    input  logic [MASTER_N-1:0]          s_w_valid,
    output logic [MASTER_N-1:0]          s_w_ready,
    output logic [1:0]                   s_b_resp,
    output logic [MASTER_N-1:0]          s_b_valid,
    input  logic [MASTER_N-1:0]          s_b_ready,
    output logic [DATA_WIDTH-1:0]        m_w_data,
    output logic [STRB_W-1:0]            m_w_strb,
    output logic                         m_w_last,
    output logic                         m_w_valid,
    input  logic                         m_w_ready,
    input  logic [1:0]                   m_b_resp,
    input  logic                         m_b_valid,
    output logic                         m_b_ready,
    output logic [CNT_W-1:0]             outstanding_cnt,
    output logic [1:0]                   err_flags
);

    if (MASTER_N < 2 || MASTER_N > MAX_MASTER_N || simulation_delay < 0) begin : g_param_out_of_range
    end

    logic [MID_W-1:0] w_head, b_head;
    logic             w_full, w_empty, b_full, b_empty;
    logic [CNT_W-1:0] w_count;
    logic             unused_w_count;
    logic             w_en, head_valid, b_head_ready;
    logic             mid_legal, w_push, w_last_hs, b_pop;
    logic [1:0]       err_q, err_d;

    assign unused_w_count = ^w_count;

    assign grant_push_ready = !w_full;
    assign mid_legal        = (grant_push_mid < MID_W'(MASTER_N));
    assign w_push           = grant_push_valid && grant_push_ready && mid_legal;
    // A full B-order FIFO stalls every beat, so a last beat can always push.
    assign w_en             = !w_empty && !b_full;

    always_comb begin
        m_w_data     = '0;
        m_w_strb     = '0;
        m_w_last     = 1'b0;
        head_valid   = 1'b0;
        s_w_ready    = '0;
        s_b_valid    = '0;
        b_head_ready = 1'b0;
        for (int i = 0; i < MASTER_N; i++) begin
            if (w_head == MID_W'(i)) begin
                m_w_data     = s_w_data[i*DATA_WIDTH +: DATA_WIDTH];
                m_w_strb     = s_w_strb[i*STRB_W +: STRB_W];
                m_w_last     = s_w_last[i];
                head_valid   = s_w_valid[i];
                s_w_ready[i] = w_en && m_w_ready;
            end
            if (b_head == MID_W'(i)) begin
                s_b_valid[i] = m_b_valid && !b_empty;
                b_head_ready = s_b_ready[i];
            end
        end
    end

    assign m_w_valid = w_en && head_valid;
    assign w_last_hs = m_w_valid && m_w_ready && m_w_last;
    assign m_b_ready = !b_empty && b_head_ready;
    assign b_pop     = m_b_valid && m_b_ready;
    assign s_b_resp  = m_b_resp;

    order_fifo #(.WIDTH(MID_W), .DEPTH(OUTSTANDING_DEPTH)) u_w_order (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (grant_push_mid),
        .pop   (w_last_hs),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    order_fifo #(.WIDTH(MID_W), .DEPTH(OUTSTANDING_DEPTH)) u_b_order (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_last_hs),
        .din   (w_head),
        .pop   (b_pop),
        .dout  (b_head),
        .count (outstanding_cnt),
        .full  (b_full),
        .empty (b_empty)
    );

    always_comb begin
        err_d    = err_q;
        err_d[0] = err_q[0] | (m_b_valid && b_empty);
        err_d[1] = err_q[1] | (grant_push_valid && grant_push_ready && !mid_legal);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= '0;
        else        err_q <= err_d;
    end

    assign err_flags = err_q;

endmodule

// File: tb/tb_axi_wb_chn_router.sv
// Directed bench for axi_wb_chn_router with 4 masters, 32-bit data and
// 2-deep order FIFOs.
module tb_axi_wb_chn_router;

    logic         clk;
    logic         rst_n;
    logic         grant_push_valid;
    logic         grant_push_ready;
    logic [2:0]   grant_push_mid;
    logic [127:0] s_w_data;
    logic [15:0]  s_w_strb;
    logic [3:0]   s_w_last;
    logic [3:0]   s_w_valid;
    logic [3:0]   s_w_ready;
    logic [1:0]   s_b_resp;
    logic [3:0]   s_b_valid;
    logic [3:0]   s_b_ready;
    logic [31:0]  m_w_data;
    logic [3:0]   m_w_strb;
    logic         m_w_last;
    logic         m_w_valid;
    logic         m_w_ready;
    logic [1:0]   m_b_resp;
    logic         m_b_valid;
    logic         m_b_ready;
    logic [1:0]   outstanding_cnt;
    logic [1:0]   err_flags;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axi_wb_chn_router #(
        .MASTER_N          (4),
        .DATA_WIDTH        (32),
        .OUTSTANDING_DEPTH (2),
        .simulation_delay  (1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .grant_push_valid (grant_push_valid),
        .grant_push_ready (grant_push_ready),
        .grant_push_mid   (grant_push_mid),
        .s_w_data         (s_w_data),
        .s_w_strb         (s_w_strb),
        .s_w_last         (s_w_last),
        .s_w_valid        (s_w_valid),
        .s_w_ready        (s_w_ready),
        .s_b_resp         (s_b_resp),
        .s_b_valid        (s_b_valid),
        .s_b_ready        (s_b_ready),
        .m_w_data         (m_w_data),
        .m_w_strb         (m_w_strb),
        .m_w_last         (m_w_last),
        .m_w_valid        (m_w_valid),
        .m_w_ready        (m_w_ready),
        .m_b_resp         (m_b_resp),
        .m_b_valid        (m_b_valid),
        .m_b_ready        (m_b_ready),
        .outstanding_cnt  (outstanding_cnt),
        .err_flags        (err_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish before 100000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        if (obs !== exp) $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        else             pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_push_rdy"}, grant_push_ready, 1'b1);
        chk({tag, "_m_w_valid"}, m_w_valid, 1'b0);
        chk({tag, "_s_w_ready"}, s_w_ready, 4'b0000);
        chk({tag, "_s_b_valid"}, s_b_valid, 4'b0000);
        chk({tag, "_m_b_ready"}, m_b_ready, 1'b0);
        chk({tag, "_outst"}, outstanding_cnt, 2'd0);
        chk({tag, "_err"}, err_flags, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        grant_push_valid = 1'b0;
        grant_push_mid = '0;
        s_w_data = '0;
        s_w_strb = '1;
        s_w_last = '0;
        s_w_valid = '0;
        s_b_ready = '0;
        m_w_ready = 1'b0;
        m_b_resp = 2'b00;
        m_b_valid = 1'b0;
        #3;
        chk_reset_state("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Orphan B with nothing outstanding
        m_b_valid = 1'b1;
        s_b_ready = 4'b1111;
        #3;
        chk("orphan_m_b_ready", m_b_ready, 1'b0);
        chk("orphan_s_b_valid", s_b_valid, 4'b0000);
        step();
        chk("orphan_err", err_flags, 2'b01);
        $display("orphan B observed, err_flags=%b", err_flags);
        m_b_valid = 1'b0;
        s_b_ready = '0;

        // Grant master 2 then master 0; master 0 has a beat waiting all along
        m_w_ready = 1'b1;
        s_w_valid = 4'b0101;
        s_w_data[2*32 +: 32] = 32'hA0;
        s_w_data[0 +: 32] = 32'hB0;
        s_w_last = 4'b0001;
        grant_push_valid = 1'b1;
        grant_push_mid = 3'd2;
        #3;
        chk("no_bypass_valid", m_w_valid, 1'b0);
        step();
        grant_push_mid = 3'd0;
        for (int k = 0; k < 4; k++) begin
            s_w_data[2*32 +: 32] = 32'hA0 + k;
            s_w_last[2] = (k == 3);
            #3;
            chk("m2_valid", m_w_valid, 1'b1);
            chk("m2_data", m_w_data, 32'hA0 + k);
            chk("m2_s_w_ready", s_w_ready, 4'b0100);
            chk("m2_last", m_w_last, (k == 3));
            $display("W beat master 2 data=%0h last=%0b", m_w_data, m_w_last);
            step();
            grant_push_valid = 1'b0;
        end
        #3;
        chk("m0_data", m_w_data, 32'hB0);
        chk("m0_s_w_ready", s_w_ready, 4'b0001);
        chk("m0_last", m_w_last, 1'b1);
        chk("outst_after_b2", outstanding_cnt, 2'd1);
        $display("W beat master 0 data=%0h last=%0b", m_w_data, m_w_last);
        step();
        s_w_valid = '0;
        #3;
        chk("outst_two", outstanding_cnt, 2'd2);
        chk("w_idle_valid", m_w_valid, 1'b0);

        // Third burst (master 1) is blocked while the B-order FIFO is full
        grant_push_valid = 1'b1;
        grant_push_mid = 3'd1;
        step();
        grant_push_valid = 1'b0;
        s_w_valid = 4'b0010;
        s_w_data[1*32 +: 32] = 32'hC0;
        s_w_last = 4'b0010;
        #3;
        chk("full_blk_valid", m_w_valid, 1'b0);
        chk("full_blk_ready", s_w_ready, 4'b0000);
        step();
        #3;
        chk("full_blk_valid2", m_w_valid, 1'b0);

        // First B (OKAY) goes to master 2
        m_b_valid = 1'b1;
        m_b_resp = 2'b00;
        s_b_ready = 4'b0100;
        #3;
        chk("b1_s_b_valid", s_b_valid, 4'b0100);
        chk("b1_resp", s_b_resp, 2'b00);
        chk("b1_m_b_ready", m_b_ready, 1'b1);
        $display("B to master 2 resp=%b", s_b_resp);
        step();

        // Second B (SLVERR) goes to master 0; W resumes concurrently
        m_b_resp = 2'b10;
        s_b_ready = 4'b0001;
        #3;
        chk("b2_s_b_valid", s_b_valid, 4'b0001);
        chk("b2_resp", s_b_resp, 2'b10);
        chk("b2_m_b_ready", m_b_ready, 1'b1);
        chk("w_resume_valid", m_w_valid, 1'b1);
        chk("w_resume_data", m_w_data, 32'hC0);
        chk("w_resume_ready", s_w_ready, 4'b0010);
        chk("outst_one", outstanding_cnt, 2'd1);
        $display("B to master 0 resp=%b, W beat master 1 data=%0h", s_b_resp, m_w_data);
        step();
        s_w_valid = '0;
        #3;
        chk("outst_push_pop", outstanding_cnt, 2'd1);
        m_b_resp = 2'b01;
        s_b_ready = 4'b0010;
        #3;
        chk("b3_s_b_valid", s_b_valid, 4'b0010);
        chk("b3_resp", s_b_resp, 2'b01);
        $display("B to master 1 resp=%b", s_b_resp);
        step();
        m_b_valid = 1'b0;
        s_b_ready = '0;
        #3;
        chk("outst_zero", outstanding_cnt, 2'd0);

        // Illegal MID 5 is dropped
        grant_push_valid = 1'b1;
        grant_push_mid = 3'd5;
        step();
        grant_push_valid = 1'b0;
        s_w_valid = 4'b1111;
        #3;
        chk("illegal_err", err_flags, 2'b11);
        chk("illegal_no_w", m_w_valid, 1'b0);
        chk("illegal_push_rdy", grant_push_ready, 1'b1);
        $display("illegal MID push, err_flags=%b", err_flags);
        step();
        #3;
        chk("illegal_no_w2", m_w_valid, 1'b0);

        // Reset in the middle of a 4-beat master 3 burst
        s_w_valid = '0;
        grant_push_valid = 1'b1;
        grant_push_mid = 3'd0;
        step();
        grant_push_mid = 3'd3;
        s_w_valid = 4'b0001;
        s_w_last = 4'b0001;
        s_w_data[0 +: 32] = 32'hB1;
        step();
        grant_push_valid = 1'b0;
        s_w_valid = 4'b1000;
        s_w_last = 4'b0000;
        s_w_data[3*32 +: 32] = 32'hD0;
        step();
        s_w_data[3*32 +: 32] = 32'hD1;
        step();
        s_w_data[3*32 +: 32] = 32'hD2;
        #1;
        chk("mid_burst_valid", m_w_valid, 1'b1);
        chk("mid_burst_data", m_w_data, 32'hD2);
        chk("mid_burst_outst", outstanding_cnt, 2'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_rst");
        $display("reset asserted mid-burst, outstanding_cnt=%0d", outstanding_cnt);
        s_w_valid = '0;
        step();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
